// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the fetch stage: instruction field positions,
// NOP encoding, fetch FSM state encoding and the default reset PC.
package mips_pkg;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the instruction memory (slave).
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ack, input  imem_rdata);
    modport slave  (input  imem_req, input  imem_addr,
                    output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush inserts a NOP bubble and wins over load.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'h0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack FSM, one-entry skid buffer and
// IF/ID register. Optional counters enabled by FETCH_PERF_CNT_EN.
//
// state | meaning
// IDLE  | just out of reset, no request outstanding
// REQ   | request at PC outstanding (imem_req=1)
// HOLD  | word parked in skid buffer while IF/ID is stalled
// DROP  | orphaned request after redirect; wait for its ack and discard data
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic                 id_valid,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc4,
    output logic [5:0]           Opc,
    output logic [4:0]           id_rs,
    output logic [4:0]           id_rt,
    output logic [4:0]           id_rd,
    output logic [5:0]           id_funct,
    output logic [15:0]          id_imm
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_stall_cyc
`endif
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt, w_pc_plus4;
    logic [31:0]  r_skid, r_drop_addr;
    logic         w_req, w_load, w_flush, w_skid_ld, w_drop_ld, w_slot_free;
    logic [31:0]  w_ld_instr, w_ld_pc4;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_slot_free = !id_valid || !stall;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req       = 1'b0;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        w_skid_ld   = 1'b0;
        w_drop_ld   = 1'b0;
        w_ld_instr  = r_skid;
        w_ld_pc4    = r_pc;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
                if (redirect) begin
                    w_pc_nxt = word_align(redirect_pc);
                    w_flush  = 1'b1;
                end
            end
            ST_REQ: begin
                w_req = 1'b1;
                if (redirect) begin
                    w_pc_nxt = word_align(redirect_pc);
                    w_flush  = 1'b1;
                    if (!imem.imem_ack) begin
                        w_state_nxt = ST_DROP;
                        w_drop_ld   = 1'b1;
                    end
                end else if (imem.imem_ack && w_slot_free) begin
                    w_load     = 1'b1;
                    w_ld_instr = imem.imem_rdata;
                    w_ld_pc4   = w_pc_plus4;
                    w_pc_nxt   = w_pc_plus4;
                end else if (imem.imem_ack) begin
                    w_skid_ld   = 1'b1;
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = ST_HOLD;
                end else if (!stall) begin
                    w_flush = 1'b1;
                end
            end
            ST_HOLD: begin
                // PC already advanced past the parked word, so it equals its pc+4
                if (redirect) begin
                    w_pc_nxt    = word_align(redirect_pc);
                    w_flush     = 1'b1;
                    w_state_nxt = ST_REQ;
                end else if (!stall) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DROP: begin
                w_req   = 1'b1;
                w_flush = 1'b1;
                if (redirect) w_pc_nxt = word_align(redirect_pc);
                if (imem.imem_ack) w_state_nxt = ST_REQ;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_skid      <= NOP_INSTR;
            r_drop_addr <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_skid_ld) r_skid <= imem.imem_rdata;
            if (w_drop_ld) r_drop_addr <= r_pc;
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = (r_state == ST_DROP) ? r_drop_addr : r_pc;

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_instr (w_ld_instr),
        .i_pc4   (w_ld_pc4),
        .o_valid (id_valid),
        .o_instr (id_instr),
        .o_pc4   (id_pc4)
    );

    assign Opc      = id_instr[OPC_HI:OPC_LO];
    assign id_rs    = id_instr[RS_HI:RS_LO];
    assign id_rt    = id_instr[RT_HI:RT_LO];
    assign id_rd    = id_instr[RD_HI:RD_LO];
    assign id_funct = id_instr[FUNCT_HI:FUNCT_LO];
    assign id_imm   = id_instr[IMM_HI:IMM_LO];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched, r_perf_stall_cyc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_fetched   <= 32'h0;
            r_perf_stall_cyc <= 32'h0;
        end else begin
            if (w_load) r_perf_fetched <= r_perf_fetched + 32'd1;
            if ((r_state == ST_HOLD) || ((r_state == ST_REQ) && !imem.imem_ack))
                r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
        end
    end

    assign perf_fetched   = r_perf_fetched;
    assign perf_stall_cyc = r_perf_stall_cyc;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait fetch, stall/skid, redirect
// into DROP, redirect with ack, PC wrap and reset during DROP.
module tb_fetch_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // instance A: RESET_PC = 0, fully directed
    fetch_stage_if u_if_a ();
    logic        stall_a, redirect_a;
    logic [31:0] redirect_pc_a;
    logic        id_valid_a;
    logic [31:0] id_instr_a, id_pc4_a;
    logic [5:0]  opc_a, funct_a;
    logic [4:0]  rs_a, rt_a, rd_a;
    logic [15:0] imm_a;

    // instance B: RESET_PC = FFFF_FFFC with always-ack memory, checks PC wrap
    fetch_stage_if u_if_b ();
    logic        id_valid_b;
    logic [31:0] id_instr_b, id_pc4_b;
    logic [5:0]  opc_b, funct_b;
    logic [4:0]  rs_b, rt_b, rd_b;
    logic [15:0] imm_b;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_a, perf_stall_a, perf_fetched_b, perf_stall_b;
`endif

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .imem(u_if_a.master),
        .stall(stall_a), .redirect(redirect_a), .redirect_pc(redirect_pc_a),
        .id_valid(id_valid_a), .id_instr(id_instr_a), .id_pc4(id_pc4_a),
        .Opc(opc_a), .id_rs(rs_a), .id_rt(rt_a), .id_rd(rd_a),
        .id_funct(funct_a), .id_imm(imm_a)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched_a), .perf_stall_cyc(perf_stall_a)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst_n(rst_n), .imem(u_if_b.master),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .id_valid(id_valid_b), .id_instr(id_instr_b), .id_pc4(id_pc4_b),
        .Opc(opc_b), .id_rs(rs_b), .id_rt(rt_b), .id_rd(rd_b),
        .id_funct(funct_b), .id_imm(imm_b)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched_b), .perf_stall_cyc(perf_stall_b)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n               = 1'b0;
        stall_a             = 1'b0;
        redirect_a          = 1'b0;
        redirect_pc_a       = 32'h0;
        u_if_a.imem_ack     = 1'b0;
        u_if_a.imem_rdata   = 32'h0;
        u_if_b.imem_ack     = 1'b1;
        u_if_b.imem_rdata   = 32'h0000_0020;

        tick(); tick();
        check("rst_req",   {31'h0, u_if_a.imem_req}, 32'h0);
        check("rst_valid", {31'h0, id_valid_a}, 32'h0);
        check("rst_instr", id_instr_a, 32'h0);
        check("rst_pc4",   id_pc4_a, 32'h0);
        check("rst_opc",   {26'h0, opc_a}, 32'h0);

        // release reset: IDLE -> REQ
        rst_n = 1'b1;
        tick();
        check("first_req",  {31'h0, u_if_a.imem_req}, 32'h1);
        check("first_addr", u_if_a.imem_addr, 32'h0);
        check("b_first_addr", u_if_b.imem_addr, 32'hFFFF_FFFC);

        // zero-wait fetches
        u_if_a.imem_ack = 1'b1; u_if_a.imem_rdata = 32'h0000_0020;
        tick();
        check("zw0_instr", id_instr_a, 32'h0000_0020);
        check("zw0_opc",   {26'h0, opc_a}, 32'h0);
        check("zw0_funct", {26'h0, funct_a}, 32'h20);
        check("zw0_pc4",   id_pc4_a, 32'h4);
        check("zw0_addr",  u_if_a.imem_addr, 32'h4);
        check("b_wrap_addr", u_if_b.imem_addr, 32'h0);
        check("b_wrap_pc4",  id_pc4_b, 32'h0);
        check("b_valid",     {31'h0, id_valid_b}, 32'h1);

        u_if_a.imem_rdata = 32'h8C01_0004;
        tick();
        check("zw1_opc",   {26'h0, opc_a}, 32'h23);
        check("zw1_rt",    {27'h0, rt_a}, 32'h1);
        check("zw1_imm",   {16'h0, imm_a}, 32'h4);
        check("zw1_pc4",   id_pc4_a, 32'h8);
        check("zw1_addr",  u_if_a.imem_addr, 32'h8);

        // stall while ack arrives: word goes to skid, HOLD
        stall_a = 1'b1; u_if_a.imem_rdata = 32'h2002_0005;
        tick();
        u_if_a.imem_ack = 1'b0;
        check("hold_req",   {31'h0, u_if_a.imem_req}, 32'h0);
        check("hold_instr", id_instr_a, 32'h8C01_0004);
        check("hold_pc4",   id_pc4_a, 32'h8);
        check("hold_valid", {31'h0, id_valid_a}, 32'h1);
        tick();
        check("hold2_req",   {31'h0, u_if_a.imem_req}, 32'h0);
        check("hold2_instr", id_instr_a, 32'h8C01_0004);

        stall_a = 1'b0;
        tick();
        check("skid_instr", id_instr_a, 32'h2002_0005);
        check("skid_pc4",   id_pc4_a, 32'hC);
        check("skid_opc",   {26'h0, opc_a}, 32'h08);
        check("skid_rt",    {27'h0, rt_a}, 32'h2);
        check("resume_req",  {31'h0, u_if_a.imem_req}, 32'h1);
        check("resume_addr", u_if_a.imem_addr, 32'hC);

        // no ack, not stalled: bubble
        tick();
        check("bubble_valid", {31'h0, id_valid_a}, 32'h0);
        check("bubble_instr", id_instr_a, 32'h0);
        check("bubble_addr",  u_if_a.imem_addr, 32'hC);

        u_if_a.imem_ack = 1'b1; u_if_a.imem_rdata = 32'h0109_5020;
        tick();
        u_if_a.imem_ack = 1'b0;
        check("add_instr", id_instr_a, 32'h0109_5020);
        check("add_rd",    {27'h0, rd_a}, 32'hA);
        check("add_rs",    {27'h0, rs_a}, 32'h8);
        check("add_addr",  u_if_a.imem_addr, 32'h10);

        // redirect while request to 0x10 pending -> DROP
        redirect_a = 1'b1; redirect_pc_a = 32'h0000_0102;
        tick();
        redirect_a = 1'b0;
        check("drop_valid", {31'h0, id_valid_a}, 32'h0);
        check("drop_req",   {31'h0, u_if_a.imem_req}, 32'h1);
        check("drop_addr",  u_if_a.imem_addr, 32'h10);
        tick();
        check("drop2_addr",  u_if_a.imem_addr, 32'h10);
        check("drop2_valid", {31'h0, id_valid_a}, 32'h0);
        u_if_a.imem_ack = 1'b1; u_if_a.imem_rdata = 32'hDEAD_BEEF;
        tick();
        u_if_a.imem_ack = 1'b0;
        check("orph_valid", {31'h0, id_valid_a}, 32'h0);
        check("orph_instr", id_instr_a, 32'h0);
        check("new_addr",   u_if_a.imem_addr, 32'h100);
        check("new_req",    {31'h0, u_if_a.imem_req}, 32'h1);
        u_if_a.imem_ack = 1'b1; u_if_a.imem_rdata = 32'h1234_5678;
        tick();
        check("tgt_instr", id_instr_a, 32'h1234_5678);
        check("tgt_pc4",   id_pc4_a, 32'h104);
        check("tgt_addr",  u_if_a.imem_addr, 32'h104);

        // redirect and ack in the same cycle
        u_if_a.imem_rdata = 32'hCAFE_BABE;
        redirect_a = 1'b1; redirect_pc_a = 32'h0000_0200;
        tick();
        redirect_a = 1'b0; u_if_a.imem_ack = 1'b0;
        check("rdack_valid", {31'h0, id_valid_a}, 32'h0);
        check("rdack_instr", id_instr_a, 32'h0);
        check("rdack_addr",  u_if_a.imem_addr, 32'h200);
        check("rdack_req",   {31'h0, u_if_a.imem_req}, 32'h1);

        // enter DROP, then reset with a late ack
        redirect_a = 1'b1; redirect_pc_a = 32'h0000_0300;
        tick();
        redirect_a = 1'b0;
        check("drop3_addr", u_if_a.imem_addr, 32'h200);
        rst_n = 1'b0; u_if_a.imem_ack = 1'b1; u_if_a.imem_rdata = 32'hBAD0_BAD0;
        tick();
        check("mrst_req",   {31'h0, u_if_a.imem_req}, 32'h0);
        check("mrst_valid", {31'h0, id_valid_a}, 32'h0);
        check("mrst_instr", id_instr_a, 32'h0);
        check("mrst_pc4",   id_pc4_a, 32'h0);
        rst_n = 1'b1;
        tick();
        check("late_valid", {31'h0, id_valid_a}, 32'h0);
        check("late_instr", id_instr_a, 32'h0);
        check("restart_req",  {31'h0, u_if_a.imem_req}, 32'h1);
        check("restart_addr", u_if_a.imem_addr, 32'h0);
        u_if_a.imem_rdata = 32'h0000_0020;
        tick();
        u_if_a.imem_ack = 1'b0;
        check("restart_instr", id_instr_a, 32'h0000_0020);
        check("restart_pc4",   id_pc4_a, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
